// File: rtl/pid_mc_controller_pkg.sv
// Shared types and width helpers for the time-multiplexed PID controller.
package pid_mc_controller_pkg;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_UPD, S_OUT} state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_GAIN_W = 8;
    localparam int DEF_ACC_W  = 16;

    // Gain (zero-extended) times an error difference of DATA_W+2 bits fits here.
    function automatic int prod_width(input int data_w, input int gain_w);
        return data_w + gain_w + 2;
    endfunction

    function automatic int sum_width(input int acc_w, input int prod_w);
        return ((acc_w > prod_w) ? acc_w : prod_w) + 2;
    endfunction

endpackage

// File: rtl/pid_mc_controller_sat.sv
// Signed saturator: clamps a wide signed value into [LO, HI] and truncates to OUT_W bits.
module pid_sat #(
    parameter int                      IN_W  = 20,
    parameter int                      OUT_W = 16,
    parameter logic signed [IN_W-1:0]  LO    = {1'b1, {(IN_W-1){1'b0}}},
    parameter logic signed [IN_W-1:0]  HI    = {1'b0, {(IN_W-1){1'b1}}}
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] dout
);

    logic signed [IN_W-1:0] clamped;

    always_comb begin
        clamped = din;
        if (din > HI) begin
            clamped = HI;
        end else if (din < LO) begin
            clamped = LO;
        end
        dout = clamped[OUT_W-1:0];
    end

endmodule

// File: rtl/pid_mc_controller.sv
// PID controller for NCH loops sharing one multiply/accumulate datapath, with
// per-channel integrator and previous-error registers and clamp-style anti-windup.
module pid_mc_controller
    import pid_mc_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int GAIN_W = DEF_GAIN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int NCH    = 4,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
    input  logic [GAIN_W-1:0] kd,
    input  logic              clr_valid,
    input  logic [CH_W-1:0]   clr_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] control_signal
);

    localparam int ERR_W  = DATA_W + 1;
    localparam int PROD_W = prod_width(DATA_W, GAIN_W);
    localparam int SUM_W  = sum_width(ACC_W, PROD_W);
    localparam logic [CH_W:0]             NCH_V  = (CH_W+1)'(NCH);
    localparam logic signed [SUM_W-1:0]   ACC_HI = SUM_W'({(ACC_W-1){1'b1}});
    localparam logic signed [SUM_W-1:0]   ACC_LO = ~ACC_HI;
    localparam logic signed [SUM_W-1:0]   OUT_HI = SUM_W'({DATA_W{1'b1}});

    state_t                    state_q, state_d;
    logic                      in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic                      ch_ok_q, ch_ok_d;
    logic [DATA_W-1:0]         sp_q, sp_d, fb_q, fb_d, ctrl_q, ctrl_d;
    logic [GAIN_W-1:0]         kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [PROD_W-1:0]  p_q, p_d, ki_term_q, ki_term_d, d_q, d_d;
    logic signed [ACC_W-1:0]   integ_q [NCH];
    logic signed [ACC_W-1:0]   integ_d [NCH];
    logic signed [ERR_W-1:0]   prev_err_q [NCH];
    logic signed [ERR_W-1:0]   prev_err_d [NCH];
    logic [NCH-1:0]            prev_ok_q, prev_ok_d;

    logic [CH_W-1:0]           rd_idx;
    logic signed [ERR_W-1:0]   err_c;
    logic signed [PROD_W-1:0]  err_x, prev_x, kp_x, ki_x, kd_x, p_c, ki_c, d_c;
    logic signed [ACC_W-1:0]   integ_cur, ic, integ_new;
    logic signed [SUM_W-1:0]   integ_sum, sum_s, out_sum;
    logic                      ki_pos, ki_neg, wind;
    logic [DATA_W-1:0]         ctrl_sat;

    // Out-of-range channels read channel 0 harmlessly; their results are forced to zero.
    assign rd_idx    = ch_ok_q ? ch_q : '0;
    assign err_c     = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
    assign err_x     = PROD_W'(err_c);
    assign prev_x    = PROD_W'(prev_err_q[rd_idx]);
    assign kp_x      = PROD_W'({1'b0, kp_q});
    assign ki_x      = PROD_W'({1'b0, ki_q});
    assign kd_x      = PROD_W'({1'b0, kd_q});
    assign p_c       = kp_x * err_x;
    assign ki_c      = ki_x * err_x;
    assign d_c       = prev_ok_q[rd_idx] ? kd_x * (err_x - prev_x) : '0;

    assign integ_cur = integ_q[rd_idx];
    assign integ_sum = SUM_W'(integ_cur) + SUM_W'(ki_term_q);

    pid_sat #(.IN_W(SUM_W), .OUT_W(ACC_W), .LO(ACC_LO), .HI(ACC_HI)) u_sat_integ (
        .din  (integ_sum),
        .dout (ic)
    );

    // Integration is frozen when the unclamped output is already pushed past a rail
    // in the same direction the integrator is moving.
    assign sum_s     = SUM_W'(p_q) + SUM_W'(ic) + SUM_W'(d_q);
    assign ki_pos    = !ki_term_q[PROD_W-1] && (ki_term_q != '0);
    assign ki_neg    = ki_term_q[PROD_W-1];
    assign wind      = ((sum_s > OUT_HI) && ki_pos) || (sum_s[SUM_W-1] && ki_neg);
    assign integ_new = wind ? integ_cur : ic;
    assign out_sum   = SUM_W'(p_q) + SUM_W'(integ_new) + SUM_W'(d_q);

    pid_sat #(.IN_W(SUM_W), .OUT_W(DATA_W), .LO('0), .HI(OUT_HI)) u_sat_out (
        .din  (out_sum),
        .dout (ctrl_sat)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ch_d        = ch_q;
        ch_ok_d     = ch_ok_q;
        sp_d        = sp_q;
        fb_d        = fb_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        kd_d        = kd_q;
        err_d       = err_q;
        p_d         = p_q;
        ki_term_d   = ki_term_q;
        d_d         = d_q;
        ctrl_d      = ctrl_q;
        integ_d     = integ_q;
        prev_err_d  = prev_err_q;
        prev_ok_d   = prev_ok_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    ch_d       = in_ch;
                    ch_ok_d    = ({1'b0, in_ch} < NCH_V);
                    sp_d       = setpoint;
                    fb_d       = feedback;
                    kp_d       = kp;
                    ki_d       = ki;
                    kd_d       = kd;
                    in_ready_d = 1'b0;
                    state_d    = S_MUL;
                end
            end
            S_MUL: begin
                err_d     = err_c;
                p_d       = p_c;
                ki_term_d = ki_c;
                d_d       = d_c;
                state_d   = S_UPD;
            end
            S_UPD: begin
                if (ch_ok_q) begin
                    integ_d[ch_q]    = integ_new;
                    prev_err_d[ch_q] = err_q;
                    prev_ok_d[ch_q]  = 1'b1;
                end
                ctrl_d      = ch_ok_q ? ctrl_sat : '0;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Applied last so a clear overrides a same-edge update of the same channel.
        if (clr_valid && ({1'b0, clr_ch} < NCH_V)) begin
            integ_d[clr_ch]    = '0;
            prev_err_d[clr_ch] = '0;
            prev_ok_d[clr_ch]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ch_q        <= '0;
            ch_ok_q     <= 1'b0;
            sp_q        <= '0;
            fb_q        <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            err_q       <= '0;
            p_q         <= '0;
            ki_term_q   <= '0;
            d_q         <= '0;
            ctrl_q      <= '0;
            prev_ok_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                integ_q[i]    <= '0;
                prev_err_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ch_q        <= ch_d;
            ch_ok_q     <= ch_ok_d;
            sp_q        <= sp_d;
            fb_q        <= fb_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            kd_q        <= kd_d;
            err_q       <= err_d;
            p_q         <= p_d;
            ki_term_q   <= ki_term_d;
            d_q         <= d_d;
            ctrl_q      <= ctrl_d;
            prev_ok_q   <= prev_ok_d;
            integ_q     <= integ_d;
            prev_err_q  <= prev_err_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_ch         = ch_q;
    assign control_signal = ctrl_q;

endmodule

// File: tb/tb_pid_mc_controller.sv
// Scoreboard bench for pid_mc_controller with NCH=3, so channel 3 exercises the out-of-range path.
module tb_pid_mc_controller;

    localparam int NUM_CH = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, clr_valid, out_valid, out_ready;
    logic [1:0] in_ch, clr_ch, out_ch;
    logic [7:0] setpoint, feedback, kp, ki, kd, control_signal;

    typedef struct {int ch; int ctrl;} exp_t;
    exp_t exp_q[$];

    int  errors = 0;
    int  checks = 0;
    bit  force_stall = 1'b0;

    int  m_integ [NUM_CH];
    int  m_prev  [NUM_CH];
    bit  m_ok    [NUM_CH];

    pid_mc_controller #(.DATA_W(8), .GAIN_W(8), .ACC_W(16), .NCH(NUM_CH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ch          (in_ch),
        .setpoint       (setpoint),
        .feedback       (feedback),
        .kp             (kp),
        .ki             (ki),
        .kd             (kd),
        .clr_valid      (clr_valid),
        .clr_ch         (clr_ch),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ch         (out_ch),
        .control_signal (control_signal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: textbook PID step with saturated integrator and conditional integration.
    task automatic modelSample(input int ch, input int sp_i, input int fb_i,
                               input int kp_i, input int ki_i, input int kd_i, output int ctrl);
        int err, p, kt, d, ic, s, ig;
        bit wind;
        if (ch >= NUM_CH) begin
            ctrl = 0;
            return;
        end
        err = sp_i - fb_i;
        p   = kp_i * err;
        kt  = ki_i * err;
        d   = m_ok[ch] ? kd_i * (err - m_prev[ch]) : 0;
        ic  = m_integ[ch] + kt;
        if (ic > 32767)  ic = 32767;
        if (ic < -32768) ic = -32768;
        s    = p + ic + d;
        wind = (s > 255 && kt > 0) || (s < 0 && kt < 0);
        ig   = wind ? m_integ[ch] : ic;
        m_integ[ch] = ig;
        m_prev[ch]  = err;
        m_ok[ch]    = 1'b1;
        ctrl = p + ig + d;
        if (ctrl > 255) ctrl = 255;
        if (ctrl < 0)   ctrl = 0;
    endtask

    task automatic modelClear(input int ch);
        if (ch < NUM_CH) begin
            m_integ[ch] = 0;
            m_prev[ch]  = 0;
            m_ok[ch]    = 1'b0;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) modelClear(i);
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("in_ready_timeout", 0, 1);
    endtask

    // Issues one sample, pushes its expected result, and checks the two-edge output latency.
    // Optionally pulses a clear so that it lands on the edge that leaves S_UPD.
    task automatic applyStimulus(input int ch, input int sp_i, input int fb_i, input int kp_i,
                                 input int ki_i, input int kd_i, input bit do_clr, input int clr_c);
        bit   ok;
        int   ctrl;
        exp_t e;
        waitIdle(ok);
        if (!ok) return;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        setpoint = 8'(sp_i);
        feedback = 8'(fb_i);
        kp       = 8'(kp_i);
        ki       = 8'(ki_i);
        kd       = 8'(kd_i);
        modelSample(ch, sp_i, fb_i, kp_i, ki_i, kd_i, ctrl);
        e.ch = ch;
        e.ctrl = ctrl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ch    = 2'($urandom_range(0, 3));
        setpoint = 8'($urandom_range(0, 255));
        feedback = 8'($urandom_range(0, 255));
        kp       = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        checkOutput("latency_early", int'(out_valid), 0);
        if (do_clr) begin
            clr_valid = 1'b1;
            clr_ch    = 2'(clr_c);
        end
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
        if (do_clr) modelClear(clr_c);
        checkOutput("latency_valid", int'(out_valid), 1);
    endtask

    task automatic applyClear(input int ch);
        bit ok;
        waitIdle(ok);
        clr_valid = 1'b1;
        clr_ch    = 2'(ch);
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
        modelClear(ch);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every presented output against the head of the scoreboard,
    // so any change while stalled is also caught.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                checkOutput("out_ch", int'(out_ch), exp_q[0].ch);
                checkOutput("control_signal", int'(control_signal), exp_q[0].ctrl);
                checkOutput("in_ready_busy", int'(in_ready), 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ch     = '0;
        setpoint  = '0;
        feedback  = '0;
        kp        = '0;
        ki        = '0;
        kd        = '0;
        clr_valid = 1'b0;
        clr_ch    = '0;
        out_ready = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_ch", int'(out_ch), 0);
        checkOutput("reset_control", int'(control_signal), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        // Directed cases with kp=2 ki=4 kd=1.
        applyStimulus(0, 100, 90, 2, 4, 1, 1'b0, 0);
        applyStimulus(0, 100, 90, 2, 4, 1, 1'b0, 0);
        applyStimulus(1, 255, 0, 2, 4, 1, 1'b0, 0);
        applyStimulus(1, 255, 0, 2, 4, 1, 1'b0, 0);
        applyStimulus(2, 0, 200, 2, 4, 1, 1'b0, 0);
        applyStimulus(2, 50, 50, 2, 4, 1, 1'b0, 0);
        applyStimulus(3, 200, 10, 2, 4, 1, 1'b0, 0);
        applyStimulus(0, 120, 100, 2, 4, 1, 1'b0, 0);
        applyStimulus(2, 120, 100, 2, 4, 1, 1'b0, 0);
        applyStimulus(0, 90, 100, 2, 4, 1, 1'b0, 0);

        // Consumer stall: result must hold and no new sample may be taken.
        force_stall = 1'b1;
        applyStimulus(2, 140, 100, 2, 4, 1, 1'b0, 0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", int'(in_ready), 0);
            checkOutput("stall_out_valid", int'(out_valid), 1);
        end
        force_stall = 1'b0;

        // Clear coinciding with the channel's own update, then an idle clear.
        applyStimulus(0, 150, 100, 2, 4, 1, 1'b1, 0);
        applyStimulus(0, 110, 100, 2, 4, 1, 1'b0, 0);
        applyClear(1);
        applyStimulus(1, 130, 100, 2, 4, 1, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                          ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) applyClear($urandom_range(0, 3));
        end

        // Reset while a sample sits in S_MUL: the sample is dropped and all state cleared.
        waitIdle(ok);
        in_valid = 1'b1;
        in_ch    = 2'd1;
        setpoint = 8'd200;
        feedback = 8'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_control", int'(control_signal), 0);
        checkOutput("midreset_in_ready", int'(in_ready), 1);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 100, 90, 2, 4, 1, 1'b0, 0);
        applyStimulus(1, 100, 90, 2, 4, 1, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          1'b0, 0);
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
